matrix_scan_ctrl: RTL and testbench
===================================

Name: matrix_scan_ctrl

Overview:
Upstream scan and frame-buffer stage for the 8x8 LED matrix driver. It holds a shadow frame written byte-by-byte by the host, and an active 64-bit frame (vbuf) consumed by the column mux. It generates the 3-bit column counter that feeds the column decoder and the column data mux. Between columns it inserts a blanking interval to suppress ghosting, and it swaps shadow to active only at frame boundaries, so no tearing occurs.

Parameters:
DWELL_CYCLES, 1024, clocks per column with LEDs driven; must be >= 2.
BLANK_CYCLES, 16, clocks per column with LEDs blanked before drive; must be >= 1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous reset, active-high.
wr_en  input  1  shadow byte write strobe.
wr_addr  input  3  shadow column index; selects byte wr_addr*8+7 : wr_addr*8.
wr_data  input  8  shadow byte data.
swap_req  input  1  single-cycle request to publish shadow at the next frame boundary.
swap_ack  output  1  single-cycle pulse; active frame has just been loaded from shadow.
col_counter  output  3  current column index for the decoder and mux.
vbuf  output  64  active frame; column n occupies bits 8n+7 : 8n.
blank  output  1  high means the downstream stage must drive all columns off.
frame_tick  output  1  single-cycle pulse when col_counter wraps 7->0.

Behaviour:
- Clock and reset: single clock domain, clk. Synchronous active-high reset via reset.
- Registered outputs: all outputs are registered.
- Reset values: col_counter=0, vbuf=0, blank=1, frame_tick=0, swap_ack=0. Internally, shadow=0, swap pending=0, FSM=BLANK, phase counter=0.
- FSM states: BLANK and DRIVE.
  - BLANK: blank=1. Lasts exactly BLANK_CYCLES cycles, then goes to DRIVE.
  - DRIVE: blank=0. Lasts exactly DWELL_CYCLES cycles, then goes to BLANK.
- Column advance: on the edge leaving DRIVE, col_counter increments, wrapping 7->0. col_counter never changes during DRIVE.
- Phase counter width: $clog2(max(DWELL_CYCLES, BLANK_CYCLES)) bits. It clears on every state change.
- Frame period: 8*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- frame_tick: asserted for exactly the first BLANK cycle of column 0 after a wrap. It is not asserted after reset.
- Shadow writes: a write with wr_en=1 updates the shadow byte at the next edge. Writes are accepted in any state, every cycle.
- Swap request: swap_req=1 sets swap pending. Multiple requests before a boundary coalesce into one swap.
- Swap execution: at the wrap edge (7->0), if swap pending is set or swap_req=1 in that same cycle:
  - vbuf <= shadow;
  - pending clears;
  - swap_ack=1 for one cycle, coincident with frame_tick.
- Write during swap edge: the copy takes the pre-write shadow value. The write still lands in shadow and appears at the following swap.
- Reset mid-frame: immediately returns to reset values. The pending swap and shadow contents are discarded.
- vbuf is never modified except at a swap edge or by reset.

Optional Feature:
Macro: MATRIX_SCAN_BRIGHTNESS_EN.
- When defined:
  - Adds input port brightness [3:0].
  - Within DRIVE, blank=0 only for the first ((brightness+1)*DWELL_CYCLES)/16 cycles, integer floor, minimum 1. It is 1 for the remainder of DRIVE.
  - DRIVE length and frame period are unchanged.
  - brightness is sampled at entry to DRIVE and held for that column.
- When undefined: no brightness port; behaviour is exactly as above (equivalent to brightness=15).

Decomposition:
- Package matrix_pkg:
  - constants NUM_COLS=8, COL_W=3, ROW_W=8, FRAME_W=64;
  - typedef scan_state_t enum {S_BLANK, S_DRIVE}.
- Sub-module frame_store: 8x8 shadow register file with byte write port, plus the 64-bit active register with load strobe.
- The FSM and counters stay in the top module.

Test Plan (DWELL_CYCLES=8, BLANK_CYCLES=2):
- Reset check: after reset, blank=1, col=0, vbuf=0. Then blank falls at cycle 2, rises at cycle 10, and col=1 at cycle 10. col returns to 0 at cycle 80 with frame_tick=1 for exactly one cycle.
- Swap at boundary: write bytes 0..7 with 0x01,0x02,...,0x80, then pulse swap_req at cycle 20. vbuf=0x8040201008040201 appears only at cycle 80, with swap_ack=1 coincident with frame_tick; vbuf is unchanged at cycles 20..79.
- Swap on the wrap cycle itself: swap_req asserted on cycle 79 only -> swap taken at cycle 80. Without swap_req, the frame_tick at cycle 160 has swap_ack=0.
- Write/swap collision: wr_en on cycle 79 with addr=3 data=0xAA, old shadow byte 3=0x08, swap pending. vbuf byte 3=0x08 at cycle 80. The next swap yields byte 3=0xAA.
- Reset mid-frame: assert reset at cycle 45 with a swap pending -> all outputs return to reset values. No swap_ack occurs at the next wrap.
- With MATRIX_SCAN_BRIGHTNESS_EN and brightness=3: blank=0 for 2 cycles of each 8-cycle DRIVE. The frame period stays 80 cycles.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants and types for the LED matrix scan controller.
// The optional brightness feature (MATRIX_SCAN_BRIGHTNESS_EN) uses drive_on_cycles.
package matrix_pkg;

  localparam int NUM_COLS = 8;
  localparam int COL_W    = 3;
  localparam int ROW_W    = 8;
  localparam int FRAME_W  = 64;

  typedef enum logic {
    S_BLANK,
    S_DRIVE
  } scan_state_t;

  // Number of DRIVE cycles with LEDs lit for a 4-bit brightness level; never below 1.
  function automatic int drive_on_cycles(input int level, input int dwell);
    int n;
    n = ((level + 1) * dwell) / 16;
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/frame_store.sv
// Shadow frame (8 byte-writable columns) and the active frame it is published to.
// The active frame only changes on a load strobe or reset.
module frame_store
  import matrix_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [COL_W-1:0]   wr_addr,
  input  logic [ROW_W-1:0]   wr_data,
  input  logic               load,
  output logic [FRAME_W-1:0] vbuf
);

  logic [ROW_W-1:0]   shadow [NUM_COLS];
  logic [FRAME_W-1:0] shadow_flat;

  always_comb begin
    shadow_flat = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      shadow_flat[i*ROW_W +: ROW_W] = shadow[i];
    end
  end

  // Load copies the pre-write shadow; a coincident write lands afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_COLS; i++) begin
        shadow[i] <= '0;
      end
      vbuf <= '0;
    end else begin
      if (wr_en) begin
        shadow[wr_addr] <= wr_data;
      end
      if (load) begin
        vbuf <= shadow_flat;
      end
    end
  end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Column scan FSM with inter-column blanking and tear-free frame swap for the 8x8 matrix.
// Optional MATRIX_SCAN_BRIGHTNESS_EN adds a brightness input that shortens the lit part of DRIVE.
//
// state   | meaning
// S_BLANK | all columns off, BLANK_CYCLES long, precedes each column's drive
// S_DRIVE | current column driven, DWELL_CYCLES long; column advances on exit
module matrix_scan_ctrl
  import matrix_pkg::*;
#(
  parameter int DWELL_CYCLES = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [COL_W-1:0]   wr_addr,
  input  logic [ROW_W-1:0]   wr_data,
  input  logic               swap_req,
  output logic               swap_ack,
  output logic [COL_W-1:0]   col_counter,
  output logic [FRAME_W-1:0] vbuf,
  output logic               blank,
  output logic               frame_tick
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
  ,
  input  logic [3:0]         brightness
`endif
);

  localparam int PH_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX);
  localparam logic [PH_W-1:0]  BLANK_LAST = PH_W'(BLANK_CYCLES - 1);
  localparam logic [PH_W-1:0]  DWELL_LAST = PH_W'(DWELL_CYCLES - 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(NUM_COLS - 1);

  scan_state_t      state, state_nxt;
  logic [PH_W-1:0]  phase, phase_nxt;
  logic [COL_W-1:0] col_nxt;
  logic             pend, pend_nxt;
  logic             blank_nxt, tick_nxt, load;

`ifdef MATRIX_SCAN_BRIGHTNESS_EN
  logic [PH_W:0] on_len, on_nxt;
`endif

  frame_store u_store (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .load    (load),
    .vbuf    (vbuf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_BLANK;
      phase       <= '0;
      col_counter <= '0;
      pend        <= 1'b0;
      blank       <= 1'b1;
      frame_tick  <= 1'b0;
      swap_ack    <= 1'b0;
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
      on_len      <= (PH_W+1)'(DWELL_CYCLES);
`endif
    end else begin
      state       <= state_nxt;
      phase       <= phase_nxt;
      col_counter <= col_nxt;
      pend        <= pend_nxt;
      blank       <= blank_nxt;
      frame_tick  <= tick_nxt;
      swap_ack    <= load;
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
      on_len      <= on_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase + 1'b1;
    col_nxt   = col_counter;
    tick_nxt  = 1'b0;
    load      = 1'b0;
    pend_nxt  = pend | swap_req;
    case (state)
      S_BLANK: begin
        if (phase == BLANK_LAST) begin
          state_nxt = S_DRIVE;
          phase_nxt = '0;
        end
      end
      S_DRIVE: begin
        if (phase == DWELL_LAST) begin
          state_nxt = S_BLANK;
          phase_nxt = '0;
          col_nxt   = col_counter + 1'b1;
          // Frame boundary: the only place the active frame may change.
          if (col_counter == COL_LAST) begin
            tick_nxt = 1'b1;
            if (pend || swap_req) begin
              load     = 1'b1;
              pend_nxt = 1'b0;
            end
          end
        end
      end
    endcase

`ifdef MATRIX_SCAN_BRIGHTNESS_EN
    on_nxt = on_len;
    if (state == S_BLANK && state_nxt == S_DRIVE) begin
      on_nxt = (PH_W+1)'(drive_on_cycles(int'(brightness), DWELL_CYCLES));
    end
    blank_nxt = (state_nxt == S_BLANK) || ({1'b0, phase_nxt} >= on_nxt);
`else
    blank_nxt = (state_nxt == S_BLANK);
`endif
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Self-checking bench for matrix_scan_ctrl: directed frame/swap scenarios then random traffic,
// compared every cycle against a timeline model derived from the cycle count since reset.
`timescale 1ns/1ps
module tb_matrix_scan_ctrl;

  localparam int D  = 8;
  localparam int B  = 2;
  localparam int P  = B + D;
  localparam int FP = 8 * P;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        swap_req = 1'b0;
  logic        swap_ack;
  logic [2:0]  col_counter;
  logic [63:0] vbuf;
  logic        blank;
  logic        frame_tick;
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
  logic [3:0]  brightness = 4'd3;
`endif

  matrix_scan_ctrl #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .col_counter (col_counter),
    .vbuf        (vbuf),
    .blank       (blank),
    .frame_tick  (frame_tick)
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
    ,
    .brightness  (brightness)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          t = 0;
  logic [7:0]  m_shadow [8];
  logic [63:0] m_vbuf;
  bit          m_pend;
  bit          m_ack;
  int          m_on = D;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  function automatic bit exp_blank(input int tt);
    int ph;
    ph = tt % P;
    if (ph < B) return 1'b1;
    return (ph - B) >= m_on;
  endfunction

  function automatic logic [63:0] pack_shadow();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = m_shadow[i];
    return v;
  endfunction

  // Checks cycle t, applies inputs for cycle t, advances model and DUT to t+1.
  task automatic step(input bit we, input bit [2:0] wa, input bit [7:0] wd, input bit sr);
    bit fire;
    chk("col", 64'(col_counter), 64'((t / P) % 8));
    chk("blank", 64'(blank), 64'(exp_blank(t)));
    chk("frame_tick", 64'(frame_tick), 64'((t > 0) && (t % FP == 0)));
    chk("swap_ack", 64'(swap_ack), 64'(m_ack));
    chk("vbuf", vbuf, m_vbuf);
    wr_en = we; wr_addr = wa; wr_data = wd; swap_req = sr;
    fire = (t % FP == FP - 1) && (m_pend || sr);
    if (fire) begin
      m_vbuf = pack_shadow();
      m_pend = 1'b0;
    end else begin
      m_pend = m_pend | sr;
    end
    m_ack = fire;
    if (we) m_shadow[wa] = wd;
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
    if (t % P == B - 1) begin
      m_on = ((int'(brightness) + 1) * D) / 16;
      if (m_on < 1) m_on = 1;
    end
`endif
    @(posedge clk); #1;
    t++;
  endtask

  task automatic idle_until(input int target);
    while (t < target) step(1'b0, 3'd0, 8'd0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_en = 1'b0; swap_req = 1'b0;
    @(posedge clk); #1;
    chk("rst_col", 64'(col_counter), 64'd0);
    chk("rst_blank", 64'(blank), 64'd1);
    chk("rst_tick", 64'(frame_tick), 64'd0);
    chk("rst_ack", 64'(swap_ack), 64'd0);
    chk("rst_vbuf", vbuf, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) m_shadow[i] = 8'h00;
    m_vbuf = '0; m_pend = 1'b0; m_ack = 1'b0; m_on = D;
    t = 0;
  endtask

  initial begin
    do_reset();

    // Load a walking-one pattern, request a swap mid-frame, expect it at the wrap.
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 8'(1 << i), 1'b0);
    idle_until(20);
    step(1'b0, 3'd0, 8'd0, 1'b1);
    idle_until(80);
    chk("pattern_vbuf", vbuf, 64'h8040201008040201);
    chk("pattern_ack", 64'(swap_ack), 64'd1);

    // Pending swap plus a write to byte 3 on the wrap cycle itself.
    idle_until(90);
    step(1'b1, 3'd0, 8'h55, 1'b0);
    idle_until(100);
    step(1'b0, 3'd0, 8'd0, 1'b1);
    idle_until(159);
    step(1'b1, 3'd3, 8'hAA, 1'b0);
    chk("collide_b3_old", 64'(vbuf[31:24]), 64'h08);
    chk("collide_b0_new", 64'(vbuf[7:0]), 64'h55);

    // Request only on the last cycle of the frame.
    idle_until(239);
    step(1'b0, 3'd0, 8'd0, 1'b1);
    chk("late_req_b3", 64'(vbuf[31:24]), 64'hAA);
    chk("late_req_ack", 64'(swap_ack), 64'd1);

    // No request: tick without ack.
    idle_until(320);
    chk("noreq_tick", 64'(frame_tick), 64'd1);
    chk("noreq_ack", 64'(swap_ack), 64'd0);

    // Reset mid-frame with a swap pending and fresh shadow data.
    step(1'b0, 3'd0, 8'd0, 1'b1);
    while (t < 365) step(1'b1, 3'($urandom_range(7)), 8'($urandom), 1'b0);
    do_reset();
    idle_until(80);
    chk("post_rst_ack", 64'(swap_ack), 64'd0);
    chk("post_rst_vbuf", vbuf, 64'd0);

    // Random traffic, with the occasional reset.
    for (int n = 0; n < 1600; n++) begin
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
      brightness = 4'($urandom);
`endif
      if ($urandom_range(799) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(3) == 0, 3'($urandom_range(7)), 8'($urandom),
             $urandom_range(99) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
